dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the core LSU and a word-wide backing-memory bus.
- Successor to the flat byte-addressed data memory: same core-side byte-enable write semantics, plus tags, valid bits, line refill and a req/gnt/rvalid memory interface.
- Core side is a stalling req/ack port.
- Read hits complete in the request cycle. Misses and all writes go to memory.

Parameters:
- DATA_WIDTH, 32, core and memory word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- NUM_LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  core access request; held stable with addr/we/be/data until ack_o
- we_i  in  1  0 = read, 1 = write
- be_i  in  DATA_WIDTH/8  byte enables for writes; ignored on reads
- addr_i  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
- data_i  in  DATA_WIDTH  write data
- data_o  out  DATA_WIDTH  read data; valid when ack_o is high and we_i is 0
- ack_o  out  1  access complete this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_WIDTH  word-aligned memory address
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read response valid; responses return in order, at least 1 cycle after gnt
- mem_rdata_i  in  DATA_WIDTH  read response data
- hit_cnt_o  out  32  read-hit counter; 0 when DCACHE_STATS_EN is undefined
- miss_cnt_o  out  32  read-miss counter; 0 when DCACHE_STATS_EN is undefined

Behaviour:
- Reset (async, active-low):
  - All valid bits cleared; FSM goes to IDLE.
  - ack_o=0, mem_req_o=0, mem_we_o=0, data_o=0, counters=0.
  - Data and tag arrays are not reset.
- Address split: offset = log2(WORDS_PER_LINE) bits above the byte bits; index = log2(NUM_LINES) bits above offset; tag = remaining upper bits.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, req_i & !we_i & hit:
  - ack_o=1 combinationally in the same cycle; data_o = stored word.
  - Zero latency; the state stays IDLE.
- IDLE, req_i & !we_i & miss: go to REFILL, ack_o=0.
- REFILL:
  - Issues WORDS_PER_LINE read requests at line_base + k*(DATA_WIDTH/8), k = 0..WORDS_PER_LINE-1, with mem_be_o all ones.
  - A request counter advances on each mem_gnt_i; mem_req_o drops once all requests are granted.
  - A response counter writes each mem_rdata_i into word k of the line.
  - After the last response: write the tag, set valid, return to IDLE. The next cycle is a hit and acks.
  - Minimum read-miss latency = WORDS_PER_LINE + 2 cycles from req_i.
- IDLE, req_i & we_i: go to WRITE.
- WRITE:
  - Drive mem_req_o=1, mem_we_o=1, address, be_i and data_i.
  - On mem_gnt_i: ack_o=1 in the same cycle and return to IDLE.
  - If the line hits, merge the enabled bytes into the line in the gnt cycle.
  - A miss does not allocate.
  - be_i=0 still performs a bus write with zero enables.
- mem_req_o and its payload stay stable until mem_gnt_i.
- req_i while busy is not acknowledged. The core must not change the request before ack_o.
- Reset mid-REFILL or mid-WRITE aborts the operation and leaves the line invalid. The memory side is reset on the same rst_n, so no stale rvalid arrives.
- An address with the same index but a different tag evicts by overwrite; no write-back is needed.
- Refill counters wrap at WORDS_PER_LINE. The line base is computed with offset bits zeroed.

Optional Feature:
- DCACHE_STATS_EN defined:
  - hit_cnt_o increments on each acked read hit that did not follow a refill.
  - miss_cnt_o increments on each REFILL entry.
  - Both counters saturate at 2^32-1.
- DCACHE_STATS_EN undefined: no counter logic; both outputs tied to 0.

Decomposition:
- Package dcache_pkg:
  - state enum dcache_state_e {IDLE, REFILL, WRITE}.
  - Widths derived with $clog2: BYTE_OFF_W, WORD_OFF_W, INDEX_W, TAG_W.
  - Line address helper function.
- Sub-module dcache_line_store:
  - Holds the valid bits (with async reset), the tag array and the data array.
  - One combinational read port and one byte-masked write port (refill word or write merge).
  - Its hit output compares the stored tag with the input tag.

Test Plan:
- Cold read 0x40 with memory words 0x40..0x4C = 0xA0,0xA1,0xA2,0xA3 and gnt always 1, rvalid 1 cycle later:
  - 4 bus reads at 0x40/44/48/4C; ack_o after 6 cycles with data_o=0xA0; miss_cnt_o=1.
- Then read 0x48: ack_o in the same cycle, data_o=0xA2, no mem_req_o; hit_cnt_o=1.
- Write 0x44, be=0b0010, data=0x0000BB00 on a hit line, gnt delayed 3 cycles:
  - mem_req_o stable for 4 cycles; ack on gnt.
  - A later read of 0x44 hits with data_o = (0xA1 & ~0xFF00) | 0xBB00.
- Write miss at 0x200: one bus write; a following read of 0x200 misses and refills (no allocate on write).
- Conflict: read 0x40, then 0x40 + NUM_LINES*WORDS_PER_LINE*4 = 0x140, then 0x40 → three refills.
- Assert rst_n low in the 2nd cycle of a refill:
  - mem_req_o=0 and ack_o=0 immediately.
  - After release, read 0x40 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the dcache_dm direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } dcache_state_e;

  localparam int unsigned DCACHE_DATA_WIDTH     = 32;
  localparam int unsigned DCACHE_ADDR_WIDTH     = 32;
  localparam int unsigned DCACHE_NUM_LINES      = 16;
  localparam int unsigned DCACHE_WORDS_PER_LINE = 4;

  localparam int unsigned BYTE_OFF_W = $clog2(DCACHE_DATA_WIDTH / 8);
  localparam int unsigned WORD_OFF_W = $clog2(DCACHE_WORDS_PER_LINE);
  localparam int unsigned INDEX_W    = $clog2(DCACHE_NUM_LINES);
  localparam int unsigned TAG_W      = DCACHE_ADDR_WIDTH - INDEX_W - WORD_OFF_W - BYTE_OFF_W;

  // Clears the low_w least significant address bits (word or line alignment).
  function automatic logic [63:0] line_base_addr(input logic [63:0] addr, input int unsigned low_w);
    return addr & ~((64'd1 << low_w) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid bits, tag array and data array of dcache_dm: one combinational read
// port and one byte-masked write port sharing the line index.
module dcache_line_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned WORD_OFF_W = 2,
  parameter int unsigned TAG_W      = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_W-1:0]      index_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [WORD_OFF_W-1:0]   rd_offset_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    hit_o,
  input  logic                    wr_en_i,
  input  logic [WORD_OFF_W-1:0]   wr_offset_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    tag_we_i,
  input  logic                    inval_i
);

  localparam int unsigned NUM_LINES = 1 << INDEX_W;
  localparam int unsigned WPL       = 1 << WORD_OFF_W;
  localparam int unsigned BE_W      = DATA_WIDTH / 8;

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES][WPL];

  always_comb begin
    valid_d = valid_q;
    if (inval_i)  valid_d[index_i] = 1'b0;
    if (tag_we_i) valid_d[index_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[index_i] <= tag_i;
    if (wr_en_i) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) data_q[index_i][wr_offset_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = data_q[index_i][rd_offset_i];
  assign hit_o     = valid_q[index_i] && (tag_q[index_i] == tag_i);

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack core
// port and a req/gnt/rvalid memory port. Define DCACHE_STATS_EN for hit/miss counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DCACHE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DCACHE_ADDR_WIDTH,
  parameter int unsigned NUM_LINES      = DCACHE_NUM_LINES,
  parameter int unsigned WORDS_PER_LINE = DCACHE_WORDS_PER_LINE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ack_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned BO_W = $clog2(BE_W);
  localparam int unsigned WO_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IX_W = $clog2(NUM_LINES);
  localparam int unsigned TG_W = ADDR_WIDTH - IX_W - WO_W - BO_W;
  localparam logic [WO_W-1:0] LAST_WORD = WO_W'(WORDS_PER_LINE - 1);

  dcache_state_e   state_q, state_d;
  logic [WO_W-1:0] req_cnt_q, req_cnt_d;
  logic [WO_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic            req_done_q, req_done_d;

  logic [WO_W-1:0]       offset;
  logic [IX_W-1:0]       index;
  logic [TG_W-1:0]       tag;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  st_hit;
  logic [DATA_WIDTH-1:0] st_rd_data;
  logic                  st_wr_en;
  logic [WO_W-1:0]       st_wr_off;
  logic [BE_W-1:0]       st_wr_be;
  logic [DATA_WIDTH-1:0] st_wr_data;
  logic                  st_tag_we;
  logic                  st_inval;

  // The core holds the request stable until ack, so the address is used unregistered.
  assign offset    = addr_i[BO_W +: WO_W];
  assign index     = addr_i[BO_W+WO_W +: IX_W];
  assign tag       = addr_i[ADDR_WIDTH-1 -: TG_W];
  assign line_base = ADDR_WIDTH'(line_base_addr(64'(addr_i), WO_W + BO_W));
  assign word_addr = ADDR_WIDTH'(line_base_addr(64'(addr_i), BO_W));

  dcache_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_W    (IX_W),
    .WORD_OFF_W (WO_W),
    .TAG_W      (TG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .index_i     (index),
    .tag_i       (tag),
    .rd_offset_i (offset),
    .rd_data_o   (st_rd_data),
    .hit_o       (st_hit),
    .wr_en_i     (st_wr_en),
    .wr_offset_i (st_wr_off),
    .wr_be_i     (st_wr_be),
    .wr_data_i   (st_wr_data),
    .tag_we_i    (st_tag_we),
    .inval_i     (st_inval)
  );

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    req_done_d  = req_done_q;
    ack_o       = 1'b0;
    data_o      = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = word_addr;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    st_wr_en    = 1'b0;
    st_wr_off   = offset;
    st_wr_be    = '0;
    st_wr_data  = data_i;
    st_tag_we   = 1'b0;
    st_inval    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (we_i) begin
            state_d = WRITE;
          end else if (st_hit) begin
            ack_o  = 1'b1;
            data_o = st_rd_data;
          end else begin
            // The victim line is invalidated up front so a partial refill never hits.
            state_d    = REFILL;
            req_cnt_d  = '0;
            rsp_cnt_d  = '0;
            req_done_d = 1'b0;
            st_inval   = 1'b1;
          end
        end
      end

      REFILL: begin
        mem_req_o  = !req_done_q;
        mem_addr_o = line_base | (ADDR_WIDTH'(req_cnt_q) << BO_W);
        mem_be_o   = '1;
        if (!req_done_q && mem_gnt_i) begin
          req_cnt_d = req_cnt_q + WO_W'(1);
          if (req_cnt_q == LAST_WORD) req_done_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          st_wr_en   = 1'b1;
          st_wr_off  = rsp_cnt_q;
          st_wr_be   = '1;
          st_wr_data = mem_rdata_i;
          rsp_cnt_d  = rsp_cnt_q + WO_W'(1);
          if (rsp_cnt_q == LAST_WORD) begin
            st_tag_we = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = be_i;
        mem_wdata_o = data_i;
        if (mem_gnt_i) begin
          ack_o   = 1'b1;
          state_d = IDLE;
          if (st_hit) begin
            st_wr_en = 1'b1;
            st_wr_be = be_i;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      req_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      req_done_q <= req_done_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refilled_q, refilled_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // The hit that completes a refilled miss is not counted as a hit.
  always_comb begin
    refilled_d = (state_q == REFILL) && (state_d == IDLE);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == IDLE) && req_i && !we_i && st_hit && !refilled_q && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == IDLE) && (state_d == REFILL) && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refilled_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refilled_q <= refilled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized self-checking bench for dcache_dm against a line-level cache model
// and a reference memory image.
module tb_dcache_dm;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 32;
  localparam int unsigned NL        = 16;
  localparam int unsigned WPL       = 4;
  localparam int unsigned MEM_WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [3:0]    be_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic          ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;

  always #5 clk = ~clk;

  dcache_dm #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_LINES      (NL),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .ack_o        (ack_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Backing memory (updated by the DUT's bus writes) and expected image (updated by stimulus)
  logic [31:0] bus_mem [MEM_WORDS];
  logic [31:0] exp_mem [MEM_WORDS];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int unsigned cyc = 0;
  int unsigned pend = 0;
  int unsigned last_due = 0;
  int unsigned req_hi = 0;
  int unsigned unstable = 0;
  int unsigned gnt_delay = 0;
  bit          rand_mode = 1'b0;
  bit          prev_wait = 1'b0;
  bus_t        prev_txn;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: decides gnt/rvalid for the current cycle on the falling edge.
  always @(negedge clk) begin
    bus_t        t;
    bit          g;
    int unsigned due;
    int unsigned w;
    if (!rst_n) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      rsp_q.delete();
      pend      = 0;
      prev_wait = 1'b0;
      last_due  = 0;
    end else begin
      g = 1'b0;
      if (mem_req_o) begin
        t.we = mem_we_o; t.addr = mem_addr_o; t.be = mem_be_o; t.wdata = mem_wdata_o;
        req_hi++;
        if (prev_wait && (t.we != prev_txn.we || t.addr != prev_txn.addr ||
                          t.be != prev_txn.be || t.wdata != prev_txn.wdata))
          unstable++;
        g = rand_mode ? ($urandom_range(0, 2) != 0) : (pend >= gnt_delay);
        if (g) begin
          pend = 0;
          bus_q.push_back(t);
          w = (t.addr >> 2) % MEM_WORDS;
          if (t.we) begin
            for (int b = 0; b < 4; b++)
              if (t.be[b]) bus_mem[w][8*b +: 8] = t.wdata[8*b +: 8];
          end else begin
            due = cyc + (rand_mode ? $urandom_range(1, 3) : 1);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_q.push_back('{due: due, data: bus_mem[w]});
          end
        end else begin
          pend++;
        end
        prev_wait = !g;
        prev_txn  = t;
      end else begin
        pend      = 0;
        prev_wait = 1'b0;
      end
      mem_gnt_i = g;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
    end
  end

  // Line-level cache model
  bit          ref_valid [NL];
  int unsigned ref_tag   [NL];
  int unsigned hit_m  = 0;
  int unsigned miss_m = 0;

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
    check_eq({tag, "_hit_cnt"}, hit_cnt_o, hit_m);
    check_eq({tag, "_miss_cnt"}, miss_cnt_o, miss_m);
`else
    check_eq({tag, "_hit_cnt"}, hit_cnt_o, 32'd0);
    check_eq({tag, "_miss_cnt"}, miss_cnt_o, 32'd0);
`endif
  endtask

  // One core access; lat_exp < 0 skips the exact latency check.
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int lat_exp);
    int unsigned start, lat, idx, tg, w, hi0;
    bit          exp_hit, got;
    logic [31:0] base;
    w       = (addr >> 2) % MEM_WORDS;
    idx     = (addr >> 4) % NL;
    tg      = addr >> 8;
    base    = addr & ~32'hF;
    exp_hit = !we && ref_valid[idx] && (ref_tag[idx] == tg);
    bus_q.delete();
    hi0     = req_hi;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; data_i = wd;
    start = cyc;
    got   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (ack_o) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      check_eq("ack_timeout", 32'd0, 32'd1);
      summary_and_finish();
    end
    lat = cyc - start;
    if (!we) begin
      check_eq("rd_data", data_o, exp_mem[w]);
      check_eq("rd_hit", (bus_q.size() == 0) ? 32'd1 : 32'd0, exp_hit ? 32'd1 : 32'd0);
      if (exp_hit) begin
        check_eq("hit_latency", lat, 32'd0);
        check_eq("hit_no_bus", req_hi - hi0, 32'd0);
        hit_m++;
      end else begin
        check_eq("refill_reads", bus_q.size(), WPL);
        for (int k = 0; k < bus_q.size() && k < int'(WPL); k++) begin
          check_eq("refill_we", {31'b0, bus_q[k].we}, 32'd0);
          check_eq("refill_addr", bus_q[k].addr, base + 32'(4 * k));
          check_eq("refill_be", {28'b0, bus_q[k].be}, 32'hF);
        end
        miss_m++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
    end else begin
      check_eq("wr_count", bus_q.size(), 32'd1);
      if (bus_q.size() > 0) begin
        check_eq("wr_we", {31'b0, bus_q[0].we}, 32'd1);
        check_eq("wr_addr", bus_q[0].addr, addr & ~32'h3);
        check_eq("wr_be", {28'b0, bus_q[0].be}, {28'b0, be});
        check_eq("wr_data", bus_q[0].wdata, wd);
      end
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[w][8*b +: 8] = wd[8*b +: 8];
    end
    if (lat_exp >= 0) check_eq("latency", lat, lat_exp);
    @(posedge clk); #1;
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  initial begin
    int unsigned h, bad;
    logic [31:0] v;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      v = $urandom;
      bus_mem[i] = v;
      exp_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      bus_mem[16 + i] = 32'hA0 + 32'(i);
      exp_mem[16 + i] = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < int'(NL); i++) ref_valid[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'b0, ack_o}, 32'd0);
    check_eq("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check_eq("rst_data", data_o, 32'd0);
    check_stats("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 32'h40, 4'h0, 32'h0, 6);
    check_stats("cold");
    access(1'b0, 32'h48, 4'h0, 32'h0, 0);
    check_stats("hit");

    gnt_delay = 3;
    h = req_hi;
    access(1'b1, 32'h44, 4'b0010, 32'h0000BB00, 4);
    check_eq("wr_req_cycles", req_hi - h, 32'd4);
    gnt_delay = 0;
    access(1'b0, 32'h44, 4'h0, 32'h0, 0);
    check_eq("merged_word", exp_mem[17], 32'h0000BBA1);

    access(1'b1, 32'h200, 4'hF, 32'h12345678, 1);
    access(1'b0, 32'h200, 4'h0, 32'h0, 6);
    access(1'b1, 32'h48, 4'h0, 32'hDEADBEEF, 1);
    access(1'b0, 32'h48, 4'h0, 32'h0, 0);

    // Reset in the second cycle of a refill
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h140;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check_eq("mid_rst_ack", {31'b0, ack_o}, 32'd0);
    req_i = 1'b0;
    for (int i = 0; i < int'(NL); i++) ref_valid[i] = 1'b0;
    hit_m = 0;
    miss_m = 0;
    @(posedge clk); #1;
    check_stats("mid_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 32'h40, 4'h0, 32'h0, 6);
    access(1'b0, 32'h140, 4'h0, 32'h0, 6);
    access(1'b0, 32'h40, 4'h0, 32'h0, 6);
    check_stats("conflict");

    rand_mode = 1'b1;
    repeat (300) begin
      access($urandom_range(0, 2) == 0, 32'($urandom_range(0, 1023)),
             4'($urandom), $urandom, -1);
    end
    check_stats("random");
    check_eq("payload_stable", unstable, 32'd0);
    bad = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++)
      if (bus_mem[i] !== exp_mem[i]) bad++;
    check_eq("mem_image", bad, 32'd0);

    summary_and_finish();
  end

endmodule
